run_length_detector: RTL

Parametrised Moore-style serial pattern detector. Asserts `z` once the last `RUN_LEN` accepted bits on `w` are all equal, for either polarity. It keeps `z` high for as long as the run continues, and reports which value formed the run. It sits on the same single-bit serial input paths as the fixed two-bit equal-run detector and supersedes it. It adds run length, input qualification, synchronous clear, and an optional detection-event counter.

---
 rtl/rundet_pkg.sv | 24 ++
 rtl/sat_counter.sv | 30 +++
 rtl/run_length_detector.sv | 103 ++++++++++
 3 files changed

// File: rtl/rundet_pkg.sv
// ============================================================================
// rundet_pkg : shared types, limits and helpers for run_length_detector
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

package rundet_pkg;

    localparam int RUN_LEN_MIN = 2;
    localparam int RUN_LEN_MAX = 255;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } rundet_state_t;

    // len counts 0..RUN_LEN inclusive, so it needs room for RUN_LEN itself
    function automatic int len_width(input int run_len);
        return $clog2(run_len + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// sat_counter : up-counter that sticks at all-ones instead of wrapping
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/run_length_detector.sv
// ============================================================================
// run_length_detector : Moore detector for RUN_LEN equal qualified bits on w.
// Optional detection-event counter enabled by macro RUNDET_COUNT_EN.
// Rev 1.0             : initial release
// ============================================================================
`default_nettype none

module run_length_detector
    import rundet_pkg::*;
#(
    parameter int RUN_LEN = 2,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             w,
    output logic             z,
    output logic             z_val
`ifdef RUNDET_COUNT_EN
    ,
    output logic [CNT_W-1:0] det_cnt
`endif
);

    localparam int                LEN_W    = len_width(RUN_LEN);
    localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(RUN_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    rundet_state_t    st_q, st_d;
    logic             prev_q, prev_d;
    logic [LEN_W-1:0] len_q, len_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q   <= IDLE;
            prev_q <= 1'b0;
            len_q  <= '0;
        end else begin
            st_q   <= st_d;
            prev_q <= prev_d;
            len_q  <= len_d;
        end
    end

    always_comb begin
        st_d   = st_q;
        prev_d = prev_q;
        len_d  = len_q;
        if (clr) begin
            st_d   = IDLE;
            prev_d = 1'b0;
            len_d  = '0;
        end else if (en) begin
            case (st_q)
                IDLE: begin
                    st_d   = RUN;
                    prev_d = w;
                    len_d  = LEN_ONE;
                end
                RUN: begin
                    if (w == prev_q) begin
                        if (len_q != LEN_FULL) begin
                            len_d = len_q + LEN_ONE;
                        end
                    end else begin
                        // a differing bit is the first bit of the next run
                        prev_d = w;
                        len_d  = LEN_ONE;
                    end
                end
                default: begin
                    st_d   = IDLE;
                    prev_d = 1'b0;
                    len_d  = '0;
                end
            endcase
        end
    end

    assign z     = (st_q == RUN) && (len_q == LEN_FULL);
    assign z_val = z & prev_q;

`ifdef RUNDET_COUNT_EN
    logic det_event;

    // z is about to rise: exactly one event per qualifying run
    assign det_event = (st_d == RUN) && (len_d == LEN_FULL) && !z;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_det_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (det_event),
        .cnt   (det_cnt)
    );
`endif

endmodule

`default_nettype wire
